// File: rtl/ev_op_sequencer.sv
// Opcode sequencer: captures one event (word array + opcode stream), steps the
// attached combinational execution unit one opcode per cycle, then hands the result downstream.
module ev_op_sequencer #(
  parameter int WORDS   = 64,
  parameter int WORD_W  = 32,
  parameter int OP_W    = 32,
  parameter int MAX_OPS = 8,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORDS*WORD_W-1:0]   in_words,
  input  logic [MAX_OPS*OP_W-1:0]   in_ops,
  input  logic [CNT_W-1:0]          in_op_count,
  output logic [WORDS*WORD_W-1:0]   exu_words,
  output logic [OP_W-1:0]           exu_op,
  input  logic [WORDS*WORD_W-1:0]   exu_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORDS*WORD_W-1:0]   out_words,
  output logic                      busy
);

  localparam int ARR_W = WORDS * WORD_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  logic [1:0]              r_state;
  logic [ARR_W-1:0]        r_words;
  logic [MAX_OPS*OP_W-1:0] r_ops;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_idx;

  logic [CNT_W-1:0]        w_count_clamped;
  logic [OP_W-1:0]         w_slot_op;
  logic                    w_last_op;

  // Oversized counts run the full stream rather than indexing past the last slot.
  always_comb begin
    w_count_clamped = (in_op_count > MAX_CNT) ? MAX_CNT : in_op_count;
  end

  // NOTE: every combinational output gets a default before the loop/case so no latch is inferred.
  always_comb begin
    w_slot_op = '0;
    for (int k = 0; k < MAX_OPS; k++) begin
      if (r_idx == CNT_W'(k)) begin
        w_slot_op = r_ops[k*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    w_last_op = (r_idx == (r_count - 1'b1));
  end

  // NOTE: the wide word/op registers are reset too, so an aborted event can never leak out on exu_words/out_words.
  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_words <= '0;
      r_ops   <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_words <= in_words;
            r_ops   <= in_ops;
            r_count <= w_count_clamped;
            r_idx   <= '0;
            r_state <= (w_count_clamped == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          r_words <= exu_result;
          r_idx   <= r_idx + 1'b1;
          if (w_last_op) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    busy      = (r_state == ST_RUN);
    out_valid = (r_state == ST_DONE);
    exu_words = r_words;
    out_words = r_words;
    exu_op    = (r_state == ST_RUN) ? w_slot_op : '0;
  end

endmodule

// File: tb/tb_ev_op_sequencer.sv
// Directed bench for ev_op_sequencer; a small adder model stands in for the execution unit.
module tb_ev_op_sequencer;

  localparam int WORDS   = 64;
  localparam int WORD_W  = 32;
  localparam int OP_W    = 32;
  localparam int MAX_OPS = 8;
  localparam int CNT_W   = 4;
  localparam int ARR_W   = WORDS * WORD_W;
  localparam int OPS_W   = MAX_OPS * OP_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ARR_W-1:0]  in_words;
  logic [OPS_W-1:0]  in_ops;
  logic [CNT_W-1:0]  in_op_count;
  logic [ARR_W-1:0]  exu_words;
  logic [OP_W-1:0]   exu_op;
  logic [ARR_W-1:0]  exu_result;
  logic              out_valid;
  logic              out_ready;
  logic [ARR_W-1:0]  out_words;
  logic              busy;

  int n_checks;
  int n_errors;

  ev_op_sequencer #(
    .WORDS(WORDS), .WORD_W(WORD_W), .OP_W(OP_W), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_words(in_words), .in_ops(in_ops), .in_op_count(in_op_count),
    .exu_words(exu_words), .exu_op(exu_op), .exu_result(exu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_words(out_words),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execution unit stand-in. Opcode: [31:30] kind (1 add, 2 add-imm), [29:24] dst, [23:18] a, [17:12] b, [11:0] imm.
  logic [WORD_W-1:0] m_arr [WORDS];
  always_comb begin
    for (int k = 0; k < WORDS; k++) m_arr[k] = exu_words[k*WORD_W +: WORD_W];
    case (exu_op[31:30])
      2'd1: m_arr[exu_op[29:24]] = m_arr[exu_op[23:18]] + m_arr[exu_op[17:12]];
      2'd2: m_arr[exu_op[29:24]] = m_arr[exu_op[29:24]] + {20'd0, exu_op[11:0]};
      default: ;
    endcase
    exu_result = '0;
    for (int k = 0; k < WORDS; k++) exu_result[k*WORD_W +: WORD_W] = m_arr[k];
  end

  function automatic logic [OP_W-1:0] op_add(input int dst, input int a, input int b);
    op_add = {2'd1, 6'(dst), 6'(a), 6'(b), 12'd0};
  endfunction

  function automatic logic [OP_W-1:0] op_addi(input int dst, input int imm);
    op_addi = {2'd2, 6'(dst), 12'd0, 12'(imm)};
  endfunction

  function automatic logic [ARR_W-1:0] background();
    logic [ARR_W-1:0] v;
    for (int k = 0; k < WORDS; k++) v[k*WORD_W +: WORD_W] = 32'h1000_0000 + 32'(k);
    return v;
  endfunction

  // Index of the first differing word, or -1 when equal (keeps failure lines short).
  function automatic int first_diff(input logic [ARR_W-1:0] a, input logic [ARR_W-1:0] b);
    for (int k = 0; k < WORDS; k++)
      if (a[k*WORD_W +: WORD_W] !== b[k*WORD_W +: WORD_W]) return k;
    return -1;
  endfunction

  // Drives one event from IDLE and waits (bounded) for out_valid; reports measured behaviour only.
  task automatic run_event(input logic [ARR_W-1:0] words, input logic [OPS_W-1:0] ops,
                           input logic [CNT_W-1:0] cnt,
                           output int lat, output int busy_n, output bit op_leak);
    @(negedge clk);
    in_words = words; in_ops = ops; in_op_count = cnt; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_words = '0; in_ops = '0; in_op_count = '0;
    lat = 1; busy_n = 0; op_leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      else if (exu_op !== '0) op_leak = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (exu_op !== '0) op_leak = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [ARR_W-1:0] s1_words, s1_exp, s2_words, s2_exp;
  logic [OPS_W-1:0] s1_ops, s2_ops;

  task automatic build_scenarios();
    s1_words = background();
    s1_words[1*WORD_W +: WORD_W] = 32'd35;
    s1_words[2*WORD_W +: WORD_W] = 32'd67;
    s1_ops = '0;
    s1_ops[0 +: OP_W] = op_add(6, 1, 2);
    s1_exp = s1_words;
    s1_exp[6*WORD_W +: WORD_W] = 32'd102;

    s2_words = s1_words;
    s2_words[3*WORD_W +: WORD_W] = 32'd10;
    s2_words[4*WORD_W +: WORD_W] = 32'd94;
    s2_words[5*WORD_W +: WORD_W] = 32'd154;
    s2_ops = '0;
    s2_ops[0*OP_W +: OP_W] = op_add(6, 1, 2);
    s2_ops[1*OP_W +: OP_W] = op_add(32, 3, 4);
    s2_ops[2*OP_W +: OP_W] = op_add(48, 5, 2);
    s2_ops[3*OP_W +: OP_W] = op_add(50, 6, 32);
    s2_ops[4*OP_W +: OP_W] = op_add(1, 48, 50);
    s2_exp = s2_words;
    s2_exp[6*WORD_W  +: WORD_W] = 32'd102;
    s2_exp[32*WORD_W +: WORD_W] = 32'd104;
    s2_exp[48*WORD_W +: WORD_W] = 32'd221;
    s2_exp[50*WORD_W +: WORD_W] = 32'd206;
    s2_exp[1*WORD_W  +: WORD_W] = 32'd427;
  endtask

  task automatic test_reset();
    int d;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
    n_checks++;
    if (exu_op !== '0) begin
      n_errors++; $display("FAIL reset_exu_op got %h exp 0", exu_op);
    end
    d = first_diff(out_words, '0);
    n_checks++;
    if (d >= 0 || exu_words !== '0) begin
      n_errors++; $display("FAIL reset_words word %0d nonzero after reset", d);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    int lat, bn, d; bit leak;
    run_event(s1_words, s1_ops, 4'd1, lat, bn, leak);
    n_checks++;
    if (lat !== 2 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL single_latency got %0d (valid=%b) exp 2", lat, out_valid);
    end
    d = first_diff(out_words, s1_exp);
    n_checks++;
    if (d >= 0) begin
      n_errors++;
      $display("FAIL single_words word %0d got %0d exp %0d", d, out_words[d*WORD_W +: WORD_W], s1_exp[d*WORD_W +: WORD_W]);
    end
    n_checks++;
    if (bn !== 1) begin
      n_errors++; $display("FAIL single_busy got %0d cycles exp 1", bn);
    end
    drain();
  endtask

  task automatic test_chain();
    int lat, bn, d; bit leak;
    run_event(s2_words, s2_ops, 4'd5, lat, bn, leak);
    n_checks++;
    if (lat !== 6 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL chain_latency got %0d (valid=%b) exp 6", lat, out_valid);
    end
    d = first_diff(out_words, s2_exp);
    n_checks++;
    if (d >= 0) begin
      n_errors++;
      $display("FAIL chain_words word %0d got %0d exp %0d", d, out_words[d*WORD_W +: WORD_W], s2_exp[d*WORD_W +: WORD_W]);
    end
    drain();
  endtask

  task automatic test_zero_count();
    int lat, bn, d; bit leak;
    logic [ARR_W-1:0] w;
    logic [OPS_W-1:0] ops;
    for (int k = 0; k < WORDS; k++) w[k*WORD_W +: WORD_W] = $urandom;
    for (int k = 0; k < MAX_OPS; k++) ops[k*OP_W +: OP_W] = op_addi(k, 7);
    run_event(w, ops, 4'd0, lat, bn, leak);
    n_checks++;
    if (lat !== 1 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL zero_latency got %0d (valid=%b) exp 1", lat, out_valid);
    end
    d = first_diff(out_words, w);
    n_checks++;
    if (d >= 0) begin
      n_errors++;
      $display("FAIL zero_passthru word %0d got %h exp %h", d, out_words[d*WORD_W +: WORD_W], w[d*WORD_W +: WORD_W]);
    end
    n_checks++;
    if (leak !== 1'b0 || bn !== 0) begin
      n_errors++; $display("FAIL zero_exu_op got leak=%b busy_cycles=%0d exp 0 0", leak, bn);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat, bn, d, bad; bit leak;
    run_event(s1_words, s1_ops, 4'd1, lat, bn, leak);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      d = first_diff(out_words, s1_exp);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d >= 0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL hold_no_same_cycle got in_ready=%b exp 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn, d, seen; bit leak;
    @(negedge clk);
    in_words = s2_words; in_ops = s2_ops; in_op_count = 4'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exu_op !== op_add(48, 5, 2) || busy !== 1'b1) begin
      n_errors++; $display("FAIL midrun_op2 got op=%h busy=%b exp %h 1", exu_op, busy, op_add(48, 5, 2));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || exu_op !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset_ctrl got in_ready=%b out_valid=%b busy=%b op=%h exp 1 0 0 0", in_ready, out_valid, busy, exu_op);
    end
    d = first_diff(out_words, '0);
    n_checks++;
    if (d >= 0) begin
      n_errors++; $display("FAIL midrun_reset_words word %0d got %h exp 0", d, out_words[d*WORD_W +: WORD_W]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL midrun_no_partial got %0d active cycles exp 0", seen);
    end
    run_event(s1_words, s1_ops, 4'd1, lat, bn, leak);
    d = first_diff(out_words, s1_exp);
    n_checks++;
    if (lat !== 2 || d >= 0) begin
      n_errors++; $display("FAIL midrun_recover got latency %0d diff word %0d exp 2 -1", lat, d);
    end
    drain();
  endtask

  task automatic test_count_clamp();
    int lat, bn; bit leak;
    logic [ARR_W-1:0] w;
    logic [OPS_W-1:0] ops;
    w = background();
    w[0 +: WORD_W] = 32'd0;
    for (int k = 0; k < MAX_OPS; k++) ops[k*OP_W +: OP_W] = op_addi(0, 1);
    run_event(w, ops, 4'd15, lat, bn, leak);
    n_checks++;
    if (out_words[0 +: WORD_W] !== 32'd8) begin
      n_errors++; $display("FAIL clamp_word0 got %0d exp 8", out_words[0 +: WORD_W]);
    end
    n_checks++;
    if (bn !== 8 || lat !== 9) begin
      n_errors++; $display("FAIL clamp_busy got busy=%0d latency=%0d exp 8 9", bn, lat);
    end
    drain();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_words = '0; in_ops = '0; in_op_count = '0; out_ready = 1'b0;
    build_scenarios();
    test_reset();
    test_single_op();
    test_chain();
    test_zero_count();
    test_backpressure();
    test_reset_mid_run();
    test_count_clamp();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ev_op_sequencer.md
Name: ev_op_sequencer

Overview:
- Sequencing stage directly upstream of the combinational execution units (adder and peers).
- Accepts one execution event: a word array plus a packed opcode stream.
- Presents one opcode per cycle with the current word array to the attached execution unit, latches the returned array as the new state, and advances.
- When the stream is exhausted, hands the final event downstream with a valid/ready handshake.

Parameters:
- WORDS, 64, number of 32-bit words in the event array.
- WORD_W, 32, bits per word.
- OP_W, 32, bits per opcode slot; equals the packed argument width of the execution unit.
- MAX_OPS, 8, opcode slots per event.
- CNT_W, 4, width of the op-count field; must satisfy 2**CNT_W > MAX_OPS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream event valid.
- in_ready  out  1  sequencer can accept an event.
- in_words  in  WORDS*WORD_W  initial word array; word k at bits [k*WORD_W +: WORD_W].
- in_ops  in  MAX_OPS*OP_W  opcode stream; slot 0 executes first, at bits [0 +: OP_W].
- in_op_count  in  CNT_W  number of slots to execute, 0..MAX_OPS.
- exu_words  out  WORDS*WORD_W  current array driven to the execution unit.
- exu_op  out  OP_W  current opcode driven to the execution unit.
- exu_result  in  WORDS*WORD_W  combinational array returned by the execution unit.
- out_valid  out  1  final event valid.
- out_ready  in  1  downstream accepts.
- out_words  out  WORDS*WORD_W  final array; equals the internal array register.
- busy  out  1  high in RUN.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state goes to IDLE; word register, op register and index are cleared to 0.
  - in_ready is 1; out_valid and busy are 0.
  - exu_words, exu_op and out_words read 0.
  - Any in-flight event is discarded. No partial result is ever emitted.
- IDLE:
  - in_ready is 1.
  - On in_valid, capture in_words, in_ops and count in the same edge.
  - If count is 0, go to DONE (pass-through); otherwise go to RUN with idx=0.
- RUN:
  - in_ready is 0; busy is 1.
  - exu_op = slot[idx]; exu_words = word register.
  - Each edge: word register <= exu_result; idx <= idx+1.
  - When idx == count-1, the edge goes to DONE.
  - Exactly one opcode per cycle. Results of op n are visible to op n+1; no forwarding hazards.
- DONE:
  - out_valid is 1; out_words is held stable until the handshake.
  - On out_valid && out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
  - out_ready may be low indefinitely; state and data are held.
- Count clamp: in_op_count > MAX_OPS is clamped to MAX_OPS at capture.
- Latency: accept edge to out_valid is count+1 edges for count ≥ 1, and 1 edge for count = 0.
- Word arithmetic belongs to the execution unit; the sequencer never modifies data itself.
- exu_op is 0 in IDLE and DONE.
- in_valid is ignored while not in IDLE. Upstream must hold in_valid and data until in_ready is seen high at an edge.

Test Plan:
1. Words[1]=35, [2]=67; ops = {add a1+a2→6}; count=1 → out_valid 2 edges after accept; out word6=102; other words unchanged.
2. Words[1]=35, [2]=67, [3]=10, [4]=94, [5]=154; ops = {a1+a2→6, a3+a4→32, a5+a2→48, 6+32→50, 48+50→1}; count=5 → word6=102, word32=104, word48=221, word50=206, word1=427; out_valid after 6 edges.
3. count=0 with arbitrary words → out_words equals in_words after 1 edge; exu_op stays 0 throughout.
4. Hold out_ready=0 for 10 cycles in DONE → out_valid and out_words stable, in_ready 0. Then out_ready=1 → IDLE, in_ready=1 next cycle.
5. Assert rst during RUN at op 2 of 5 → immediately IDLE, out_valid 0, words 0. A new event then completes correctly (scenario 1 values).
6. in_op_count=15 with MAX_OPS=8, ops = add immediate 1 to word0 ×8 → word0 = 8; busy high exactly 8 cycles.
